// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the serial transmit path.
// Holds the frame sequencer state encoding, the parity mode codes and the
// parity helper used when a frame carries a parity bit.
package uart_pkg;

  // Frame sequencer states: idle line, data bits, optional parity, stop bits.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } uart_state_e;

  // Parity mode codes for the PARITY parameter.
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Widest data word a frame may carry; narrower words are zero-extended.
  localparam int MAX_DATA_W = 9;

  // Even-parity bit of a word: 1 when the word holds an odd number of ones,
  // so word plus parity bit always carries an even count of ones.
  function automatic logic parity_even(input logic [MAX_DATA_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised asynchronous serial frame transmitter.
// One bit per clk_9600hz edge: start, DATA_W data bits (LSB or MSB first),
// optional parity, then STOP_BITS stop bits. The word is captured on the
// acceptance edge, so the upstream may change in_data mid-frame.
// Build macro UART_TX_HOLD_EN adds a one-entry holding register so a second
// word can be accepted while busy and frames run back-to-back.
module uart_tx_frame #(
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int LSB_FIRST = 1
) (
  input  logic              clk_9600hz,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);
  import uart_pkg::*;

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] STOP_CNT  = CNT_W'(STOP_BITS);

  // Reject parameter sets that cannot form a legal frame.
  generate
    if (DATA_W < 5 || DATA_W > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
      $error("uart_tx_frame: illegal DATA_W, PARITY or STOP_BITS");
    end
  endgenerate

  uart_state_e       state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [DATA_W-1:0] shift_r, shift_s;
  logic              tx_r, tx_s;
  logic              ready_r, ready_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              accept_s;
  logic              next_bit_s;
  logic [DATA_W-1:0] rot_s;
  logic              par_bit_s;
`ifdef UART_TX_HOLD_EN
  logic [DATA_W-1:0] hold_r, hold_s;
  logic              hold_full_r, hold_full_s;
  logic              take_in_s;
`endif

  assign accept_s   = in_valid && ready_r;
  // The shift register rotates rather than shifts, so after DATA_W bits it
  // holds the captured word again (and parity is rotation-invariant anyway).
  assign next_bit_s = (LSB_FIRST != 0) ? shift_r[0] : shift_r[DATA_W-1];
  assign rot_s      = (LSB_FIRST != 0) ? {shift_r[0], shift_r[DATA_W-1:1]}
                                       : {shift_r[DATA_W-2:0], shift_r[DATA_W-1]};
  assign par_bit_s  = parity_even(MAX_DATA_W'(shift_r)) ^ (PARITY == PAR_ODD);

  // Next state, next line level and frame bookkeeping for every bit edge.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    shift_s = shift_r;
    tx_s    = tx_r;
    done_s  = 1'b0;
`ifdef UART_TX_HOLD_EN
    hold_s      = hold_r;
    hold_full_s = hold_full_r;
    take_in_s   = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          shift_s = in_data;
          cnt_s   = CNT_ZERO;
          tx_s    = 1'b0;
          state_s = DATA;
`ifdef UART_TX_HOLD_EN
          take_in_s = 1'b1;
`endif
        end else begin
          tx_s = 1'b1;
        end
      end
      DATA: begin
        tx_s    = next_bit_s;
        shift_s = rot_s;
        if (cnt_r == LAST_DATA) begin
          cnt_s   = CNT_ZERO;
          state_s = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      uart_pkg::PARITY: begin
        tx_s    = par_bit_s;
        cnt_s   = CNT_ZERO;
        state_s = STOP;
      end
      STOP: begin
        if (cnt_r == STOP_CNT) begin
          done_s = 1'b1;
          cnt_s  = CNT_ZERO;
`ifdef UART_TX_HOLD_EN
          if (hold_full_r) begin
            shift_s     = hold_r;
            tx_s        = 1'b0;
            state_s     = DATA;
            hold_full_s = 1'b0;
          end else if (accept_s) begin
            shift_s   = in_data;
            tx_s      = 1'b0;
            state_s   = DATA;
            take_in_s = 1'b1;
          end else begin
            tx_s    = 1'b1;
            state_s = IDLE;
          end
`else
          tx_s    = 1'b1;
          state_s = IDLE;
`endif
        end else begin
          tx_s  = 1'b1;
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        tx_s    = 1'b1;
        cnt_s   = CNT_ZERO;
        state_s = IDLE;
      end
    endcase
`ifdef UART_TX_HOLD_EN
    // A word accepted while a frame runs parks in the holding register.
    hold_s      = (accept_s && !take_in_s) ? in_data : hold_s;
    hold_full_s = hold_full_s | (accept_s && !take_in_s);
    ready_s     = !hold_full_s;
`else
    ready_s     = (state_s == IDLE);
`endif
    busy_s = (state_s != IDLE);
  end

  // Sequencer state and registered outputs; reset forces the line idle at once.
  always_ff @(posedge clk_9600hz or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      shift_r <= {DATA_W{1'b0}};
      tx_r    <= 1'b1;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
      ready_r <= ready_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

`ifdef UART_TX_HOLD_EN
  // One-entry holding register for the next word; cleared by reset.
  always_ff @(posedge clk_9600hz or posedge reset) begin
    if (reset) begin
      hold_r      <= {DATA_W{1'b0}};
      hold_full_r <= 1'b0;
    end else begin
      hold_r      <= hold_s;
      hold_full_r <= hold_full_s;
    end
  end
`endif

  assign tx         = tx_r;
  assign in_ready   = ready_r;
  assign busy       = busy_r;
  assign frame_done = done_r;

endmodule
